// File: rtl/jfc_pkg.sv
// Shared definitions for the JPEG frame controller: FSM states and block-accounting widths.
package jfc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } jfc_state_e;

  localparam int BLKS_PER_MCU  = 4;
  localparam int MCU_DIM_W_DEF = 9;

  // Block coordinates are in 8-pixel units: twice the MCU range.
  function automatic int blk_coord_w(input int mcu_dim_w);
    return mcu_dim_w + 1;
  endfunction

  // Holds cols*rows*4 without overflow.
  function automatic int blk_total_w(input int mcu_dim_w);
    return 2 * mcu_dim_w + 2;
  endfunction

endpackage

// File: rtl/jfc_blk_coord.sv
// Block coordinate walker for 4:2:0 MCUs (2x2 luma blocks per MCU), raster order over MCUs.
module jfc_blk_coord
  import jfc_pkg::*;
#(
  parameter int MCU_DIM_W = MCU_DIM_W_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clear,
  input  logic                               adv,
  input  logic [MCU_DIM_W-1:0]               mcu_cols,
  input  logic [MCU_DIM_W-1:0]               mcu_rows,
  output logic [blk_coord_w(MCU_DIM_W)-1:0]  blk_x,
  output logic [blk_coord_w(MCU_DIM_W)-1:0]  blk_y,
  output logic                               last_blk
);

  logic [1:0]           sub_reg;
  logic [MCU_DIM_W-1:0] mcu_x_reg;
  logic [MCU_DIM_W-1:0] mcu_y_reg;
  logic                 col_end;
  logic                 row_end;

  assign col_end  = (mcu_x_reg == mcu_cols - MCU_DIM_W'(1));
  assign row_end  = (mcu_y_reg == mcu_rows - MCU_DIM_W'(1));
  assign last_blk = (sub_reg == 2'd3) && col_end && row_end;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      sub_reg   <= '0;
      mcu_x_reg <= '0;
      mcu_y_reg <= '0;
    end else if (adv) begin
      sub_reg <= sub_reg + 2'd1;
      if (sub_reg == 2'd3) begin
        if (col_end) begin
          mcu_x_reg <= '0;
          mcu_y_reg <= mcu_y_reg + MCU_DIM_W'(1);
        end else begin
          mcu_x_reg <= mcu_x_reg + MCU_DIM_W'(1);
        end
      end
    end
  end

  // sub[0] selects the right-hand block, sub[1] the lower one.
  assign blk_x = {mcu_x_reg, sub_reg[0]};
  assign blk_y = {mcu_y_reg, sub_reg[1]};

endmodule

// File: rtl/jpeg_frame_ctrl.sv
// Frame sequencer in front of the JPEG decoder: stream forwarding, zero-pad flush, block tagging.
// Optional DRAIN watchdog is enabled by defining JFC_WATCHDOG_EN.
module jpeg_frame_ctrl
  import jfc_pkg::*;
#(
  parameter int IN_BUS_WIDTH = 32,
  parameter int MCU_DIM_W    = MCU_DIM_W_DEF,
  parameter int WDOG_CYCLES  = 65536
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [MCU_DIM_W-1:0]               mcu_cols,
  input  logic [MCU_DIM_W-1:0]               mcu_rows,
  input  logic [IN_BUS_WIDTH-1:0]            src_data,
  input  logic                               src_valid,
  input  logic                               src_last,
  output logic                               src_ready,
  output logic [IN_BUS_WIDTH-1:0]            dec_data,
  output logic                               dec_valid,
  input  logic                               dec_request,
  input  logic                               blk_valid,
  output logic                               blk_tag_valid,
  output logic [blk_coord_w(MCU_DIM_W)-1:0]  blk_x,
  output logic [blk_coord_w(MCU_DIM_W)-1:0]  blk_y,
  output logic                               busy,
  output logic                               frame_done,
  output logic                               err_cfg,
  output logic                               err_early,
  output logic                               err_overrun,
  output logic                               err_timeout
);

  localparam int TOTAL_W = blk_total_w(MCU_DIM_W);
  localparam int PROD_W  = 2 * MCU_DIM_W;

  jfc_state_e           state_reg;
  jfc_state_e           state_next;
  logic [MCU_DIM_W-1:0] cols_reg;
  logic [MCU_DIM_W-1:0] rows_reg;
  logic [TOTAL_W-1:0]   total_reg;
  logic [TOTAL_W-1:0]   count_reg;
  logic [TOTAL_W-1:0]   count_inc;
  logic [TOTAL_W-1:0]   total_calc;
  logic [PROD_W-1:0]    dim_prod;
  logic                 accept;
  logic                 cfg_bad;
  logic                 busy_i;
  logic                 blk_hit;
  logic                 fin;
  logic                 last_blk;
  logic                 wd_hit;
  logic                 err_cfg_reg;
  logic                 err_early_reg;
  logic                 err_overrun_reg;

  assign busy_i     = (state_reg == FEED) || (state_reg == DRAIN);
  assign blk_hit    = blk_valid && busy_i;
  assign count_inc  = count_reg + TOTAL_W'(1);
  assign fin        = blk_hit && (count_inc == total_reg);
  assign dim_prod   = PROD_W'(mcu_cols) * PROD_W'(mcu_rows);
  assign total_calc = TOTAL_W'(dim_prod) * TOTAL_W'(BLKS_PER_MCU);

`ifdef JFC_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_reg;

  // Counts consecutive DRAIN cycles without a decoded block.
  always_ff @(posedge clk) begin
    if (!rst || (state_reg != DRAIN) || blk_valid) begin
      wd_cnt_reg <= '0;
    end else begin
      wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
    end
  end

  assign wd_hit      = (state_reg == DRAIN) && !blk_valid &&
                       (wd_cnt_reg == WD_W'(WDOG_CYCLES - 1));
  assign err_timeout = wd_hit;
`else
  // No counter in this build; a negative limit is impossible, so this never fires.
  assign wd_hit      = (WDOG_CYCLES < 0);
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    src_ready  = 1'b0;
    dec_valid  = 1'b0;
    dec_data   = '0;
    accept     = 1'b0;
    cfg_bad    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if ((mcu_cols == '0) || (mcu_rows == '0)) begin
            cfg_bad = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = FEED;
          end
        end
      end
      FEED: begin
        src_ready = dec_request;
        dec_valid = src_valid && dec_request;
        dec_data  = src_data;
        if (src_valid && dec_request && src_last) state_next = DRAIN;
        if (fin) state_next = DONE;
      end
      DRAIN: begin
        // Zero words flush the decoder's bit buffer.
        dec_valid = dec_request;
        if (fin || wd_hit) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= IDLE;
      cols_reg        <= '0;
      rows_reg        <= '0;
      total_reg       <= '0;
      count_reg       <= '0;
      err_cfg_reg     <= 1'b0;
      err_early_reg   <= 1'b0;
      err_overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      err_cfg_reg <= cfg_bad;
      if (accept) begin
        cols_reg        <= mcu_cols;
        rows_reg        <= mcu_rows;
        total_reg       <= total_calc;
        count_reg       <= '0;
        err_early_reg   <= 1'b0;
        err_overrun_reg <= 1'b0;
      end else if (blk_hit) begin
        count_reg <= count_inc;
      end
      // Finishing while still in FEED means src_last never went through earlier.
      if (fin && (state_reg == FEED)) err_early_reg <= 1'b1;
      if (blk_valid && !busy_i) err_overrun_reg <= 1'b1;
    end
  end

  // The final block does not advance, so blk_x/blk_y keep its coordinates after the frame.
  jfc_blk_coord #(
    .MCU_DIM_W (MCU_DIM_W)
  ) u_coord (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .adv      (blk_hit && !last_blk),
    .mcu_cols (cols_reg),
    .mcu_rows (rows_reg),
    .blk_x    (blk_x),
    .blk_y    (blk_y),
    .last_blk (last_blk)
  );

  assign busy          = busy_i;
  assign frame_done    = (state_reg == DONE);
  assign blk_tag_valid = blk_hit;
  assign err_cfg       = err_cfg_reg;
  assign err_early     = err_early_reg;
  assign err_overrun   = err_overrun_reg;

endmodule
